adc_sample_collector: RTL and testbench



---
 rtl/adc_sample_collector_pkg.sv | 30 +++
 rtl/adc_sample_collector_sync_fifo.sv | 56 +++++
 rtl/adc_sample_collector.sv | 136 +++++++++++++
 tb/tb_adc_sample_collector.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sample_collector_pkg.sv
// Shared types and field widths for the ADC sample collector and its entry FIFO.
package adc_collect_pkg;

   localparam int unsigned CHAN_W       = 4;
   localparam int unsigned TAG_W        = 12;
   localparam int unsigned SAMPLE_W     = 16;
   localparam int unsigned SEQ_W        = 16;
   localparam int unsigned DROP_CNT_W   = 16;
   localparam int unsigned SEL_W        = 8;
   localparam int unsigned ENTRY_W      = CHAN_W + TAG_W + SAMPLE_W;
   localparam int unsigned MAX_CHANNELS = 1 << CHAN_W;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_REQ  = 3'b010,
      ST_CAPT = 3'b100
   } state_t;

   // FIFO entry as seen on rd_data: {chan, tag, sample}
   typedef struct packed {
      logic [CHAN_W-1:0]   chan;
      logic [TAG_W-1:0]    tag;
      logic [SAMPLE_W-1:0] sample;
   } entry_t;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + DROP_CNT_W'(1);
   endfunction

endpackage

// File: rtl/adc_sample_collector_sync_fifo.sv
// Single-clock FIFO with registered read port; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             empty_c;
   logic             pop_c;
   logic             push_c;

   assign full_c  = (count == CW'(DEPTH));
   assign empty_c = (count == '0);
   assign pop_c   = rd_en && !empty_c;
   assign push_c  = wr_en && (!full_c || pop_c);

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop_c;
         if (pop_c) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (push_c && !pop_c)      count <= count + CW'(1);
         else if (pop_c && !push_c) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/adc_sample_collector.sv
// Round-robin ADC sample collector: polls channels, captures fresh sequence numbers into a FIFO.
// Optional macro ADC_COLLECT_TIMESTAMP_EN replaces the seq-derived tag with a 12-bit cycle counter.
module adc_sample_collector
   import adc_collect_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 8,
   parameter int unsigned FIFO_DEPTH   = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         poll_en,
   input  logic [NUM_CHANNELS-1:0]      chan_mask,
   output logic                         output_sample,
   output logic [SEL_W-1:0]             channel_select,
   input  logic [SEQ_W+SAMPLE_W-1:0]    sample_data,
   input  logic                         rd_en,
   output logic [ENTRY_W-1:0]           rd_data,
   output logic                         rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow,
   input  logic                         clr_overflow,
   output logic [DROP_CNT_W-1:0]        drop_count
);

   state_t                  state;
   logic [CHAN_W-1:0]       idx;
   logic [CHAN_W-1:0]       idx_next_c;
   logic [SEQ_W-1:0]        last_seq [MAX_CHANNELS];
   logic [MAX_CHANNELS-1:0] mask_pad_c;
   logic [SEQ_W-1:0]        seq_c;
   logic [TAG_W-1:0]        tag_c;
   logic                    push_c;
   logic                    drop_c;
   logic                    fifo_full_c;
   entry_t                  entry_c;

   assign mask_pad_c = MAX_CHANNELS'(chan_mask);
   assign seq_c      = sample_data[SAMPLE_W +: SEQ_W];
   assign idx_next_c = (idx == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : idx + CHAN_W'(1);

`ifdef ADC_COLLECT_TIMESTAMP_EN
   logic [TAG_W-1:0] ts_cnt;

   always_ff @(posedge clk) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + TAG_W'(1);
   end

   assign tag_c = ts_cnt;
`else
   assign tag_c = seq_c[TAG_W-1:0];
`endif

   // Change detection always compares the full sequence number
   assign push_c = (state == ST_CAPT) && mask_pad_c[idx] && (seq_c != last_seq[idx]);
   assign drop_c = push_c && fifo_full_c && !rd_en;

   always_comb begin
      entry_c        = '0;
      entry_c.chan   = idx;
      entry_c.tag    = tag_c;
      entry_c.sample = sample_data[SAMPLE_W-1:0];
   end

   // Polling FSM: one REQ cycle then one CAPT cycle per channel
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         idx            <= '0;
         output_sample  <= 1'b0;
         channel_select <= '0;
         for (int i = 0; i < int'(MAX_CHANNELS); i++) last_seq[i] <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (poll_en) begin
                  state          <= ST_REQ;
                  output_sample  <= 1'b1;
                  channel_select <= SEL_W'(idx);
               end
            end
            ST_REQ: begin
               state          <= ST_CAPT;
               output_sample  <= 1'b0;
               channel_select <= '0;
            end
            ST_CAPT: begin
               last_seq[idx] <= seq_c;
               idx           <= idx_next_c;
               if (poll_en) begin
                  state          <= ST_REQ;
                  output_sample  <= 1'b1;
                  channel_select <= SEL_W'(idx_next_c);
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state          <= ST_IDLE;
               output_sample  <= 1'b0;
               channel_select <= '0;
            end
         endcase
      end
   end

   // Sticky overflow and saturating drop counter; clear wins over a same-cycle drop
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clr_overflow) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop_c) begin
         overflow   <= 1'b1;
         drop_count <= sat_inc(drop_count);
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (push_c),
      .wr_data  (entry_c),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (fifo_count),
      .full_c   (fifo_full_c)
   );

endmodule

// File: tb/tb_adc_sample_collector.sv
// Self-checking bench for adc_sample_collector: the bench acts as the ADC controller
// and keeps a sweep-level reference model of captures, FIFO contents and drop status.
module tb_adc_sample_collector;

   localparam int NCH   = 8;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        poll_en;
   logic [NCH-1:0] chan_mask;
   logic        output_sample;
   logic [7:0]  channel_select;
   logic [31:0] sample_data;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic        clr_overflow;
   logic [15:0] drop_count;

   // Producer state presented by the emulated controller
   logic [15:0] p_seq [NCH];
   logic [15:0] p_smp [NCH];
   logic [2:0]  req_ch = 3'd0;

   // Reference model
   logic [15:0] m_last [NCH];
   int          m_idx;
   logic [31:0] m_q [$];
   logic        m_ovf;
   logic [15:0] m_dc;
   logic [31:0] m_rd;
   logic        m_popok;

   int errors = 0;
   int checks = 0;

   adc_sample_collector #(
      .NUM_CHANNELS (NCH),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .poll_en        (poll_en),
      .chan_mask      (chan_mask),
      .output_sample  (output_sample),
      .channel_select (channel_select),
      .sample_data    (sample_data),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .clr_overflow   (clr_overflow),
      .drop_count     (drop_count)
   );

   always #5 clk = ~clk;

   // Controller answers a request with that channel's data on the following cycle
   always @(posedge clk) if (output_sample) req_ch <= channel_select[2:0];
   assign sample_data = {p_seq[req_ch], p_smp[req_ch]};

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) m_last[c] = 16'h0;
      m_idx = 0;
      m_q.delete();
      m_ovf = 1'b0;
      m_dc  = 16'h0;
      m_rd  = 32'h0;
      m_popok = 1'b0;
   endfunction

   // One channel visit: capture rule, then optional pop / clear in the same cycle
   function automatic void model_capt(input bit pop, input bit clr);
      logic [15:0] s;
      bit push;
      s = p_seq[m_idx];
      push = chan_mask[m_idx] && (s != m_last[m_idx]);
      m_last[m_idx] = s;
      m_popok = pop && (m_q.size() > 0);
      if (m_popok) m_rd = m_q.pop_front();
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back({4'(m_idx), s[11:0], p_smp[m_idx]});
         else begin
            m_ovf = 1'b1;
            if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
         end
      end
      if (clr) begin
         m_ovf = 1'b0;
         m_dc  = 16'h0;
      end
      m_idx = (m_idx + 1) % NCH;
   endfunction

   // Poll n channels from the current index, dropping poll_en during the last REQ
   task automatic sweep(input int n, input bit pop_last, input bit clr_last);
      @(negedge clk);
      poll_en = 1'b1;
      @(posedge clk);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         checks++;
         if (output_sample !== 1'b1 || channel_select !== 8'(m_idx)) begin
            errors++;
            $display("FAIL req_phase: output_sample=%0b channel_select=%0d, expected 1/%0d",
                     output_sample, channel_select, m_idx);
         end
         if (j == n - 1) poll_en = 1'b0;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (output_sample !== 1'b0) begin
            errors++;
            $display("FAIL capt_strobe: output_sample=%0b expected 0", output_sample);
         end
         if (j == n - 1) begin
            rd_en = pop_last;
            clr_overflow = clr_last;
         end
         @(posedge clk);
         model_capt((j == n - 1) && pop_last, (j == n - 1) && clr_last);
      end
      @(negedge clk);
      rd_en = 1'b0;
      clr_overflow = 1'b0;
      if (pop_last) begin
         checks++;
         if (rd_valid !== m_popok || rd_data !== m_rd) begin
            errors++;
            $display("FAIL same_cycle_pop: rd_valid=%0b rd_data=%h expected %0b/%h",
                     rd_valid, rd_data, m_popok, m_rd);
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (output_sample !== 1'b0) begin
         errors++;
         $display("FAIL idle_park: output_sample=%0b expected 0", output_sample);
      end
      checks++;
      if (fifo_count !== 4'(m_q.size()) || overflow !== m_ovf || drop_count !== m_dc) begin
         errors++;
         $display("FAIL sweep_status: count=%0d ovf=%0b drops=%0d expected %0d/%0b/%0d",
                  fifo_count, overflow, drop_count, m_q.size(), m_ovf, m_dc);
      end
   endtask

   // Back-to-back pops; reads past empty must leave rd_data unchanged
   task automatic drain(input int k);
      @(negedge clk);
      rd_en = 1'b1;
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         m_popok = (m_q.size() > 0);
         if (m_popok) m_rd = m_q.pop_front();
         @(negedge clk);
         checks++;
         if (rd_valid !== m_popok || rd_data !== m_rd || fifo_count !== 4'(m_q.size())) begin
            errors++;
            $display("FAIL drain_pop: rd_valid=%0b rd_data=%h count=%0d expected %0b/%h/%0d",
                     rd_valid, rd_data, fifo_count, m_popok, m_rd, m_q.size());
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic bump_all_seq();
      for (int c = 0; c < NCH; c++) p_seq[c] = p_seq[c] + 16'd1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      poll_en = 1'b0;
      rd_en = 1'b0;
      clr_overflow = 1'b0;
      chan_mask = '0;
      for (int c = 0; c < NCH; c++) begin
         p_seq[c] = 16'h0;
         p_smp[c] = 16'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      checks++;
      if (output_sample !== 1'b0 || channel_select !== 8'h0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: output_sample=%0b channel_select=%0d rd_valid=%0b expected 0/0/0",
                  output_sample, channel_select, rd_valid);
      end
      checks++;
      if (rd_data !== 32'h0 || fifo_count !== 4'h0 || overflow !== 1'b0 || drop_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_fifo: rd_data=%h count=%0d ovf=%0b drops=%0d expected all 0",
                  rd_data, fifo_count, overflow, drop_count);
      end
   endtask

   task automatic test_first_sweep();
      chan_mask = 8'hFF;
      for (int c = 0; c < NCH; c++) begin
         p_seq[c] = 16'h0001;
         p_smp[c] = 16'h0100 + 16'(c);
      end
      sweep(NCH, 1'b0, 1'b0);
   endtask

   task automatic test_stale();
      sweep(NCH, 1'b0, 1'b0);
      drain(DEPTH + 1);
   endtask

   task automatic test_seq_wrap();
      p_seq[2] = 16'hFFFF;
      sweep(NCH, 1'b0, 1'b0);
      p_seq[2] = 16'h0000;
      p_smp[2] = 16'h0202;
      sweep(NCH, 1'b0, 1'b0);
      drain(3);
   endtask

   task automatic test_overflow();
      chan_mask = 8'h01;
      for (int s = 0; s < DEPTH + 2; s++) begin
         p_seq[0] = p_seq[0] + 16'd1;
         sweep(NCH, 1'b0, 1'b0);
      end
      @(negedge clk);
      clr_overflow = 1'b1;
      @(posedge clk);
      m_ovf = 1'b0;
      m_dc  = 16'h0;
      @(negedge clk);
      clr_overflow = 1'b0;
      checks++;
      if (overflow !== m_ovf || drop_count !== m_dc) begin
         errors++;
         $display("FAIL clr_overflow: ovf=%0b drops=%0d expected 0/0", overflow, drop_count);
      end
   endtask

   task automatic test_full_push_pop();
      p_seq[0] = p_seq[0] + 16'd1;
      sweep(1, 1'b1, 1'b0);
      chan_mask = 8'hFF;
      bump_all_seq();
      sweep(1, 1'b0, 1'b0);
      bump_all_seq();
      sweep(1, 1'b0, 1'b1);
      drain(DEPTH + 1);
      bump_all_seq();
      sweep(1, 1'b1, 1'b0);
      drain(2);
   endtask

   task automatic test_poll_pause();
      if (m_idx != 0) sweep(NCH - m_idx, 1'b0, 1'b0);
      bump_all_seq();
      sweep(6, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      sweep(2, 1'b0, 1'b0);
      drain(DEPTH + 1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 30; it++) begin
         chan_mask = 8'($urandom);
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 1) == 1) p_seq[c] = 16'($urandom);
            p_smp[c] = 16'($urandom);
         end
         sweep(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) drain(int'($urandom_range(1, 10)));
      end
      drain(DEPTH + 1);
   endtask

   task automatic test_reset_mid();
      chan_mask = 8'hFF;
      bump_all_seq();
      sweep(3, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      checks++;
      if (fifo_count !== 4'h0 || overflow !== 1'b0 || drop_count !== 16'h0 ||
          rd_valid !== 1'b0 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: count=%0d ovf=%0b drops=%0d rd_valid=%0b rd_data=%h expected zeros",
                  fifo_count, overflow, drop_count, rd_valid, rd_data);
      end
      for (int c = 0; c < NCH; c++) begin
         p_seq[c] = 16'(c);
         p_smp[c] = 16'hA000 + 16'(c);
      end
      sweep(NCH, 1'b0, 1'b0);
      drain(NCH);
   endtask

   initial begin
      test_reset();
      test_first_sweep();
      test_stale();
      test_seq_wrap();
      test_overflow();
      test_full_push_pop();
      test_poll_pause();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
